fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the five-stage pipeline; replaces the free-running PC/Incrementor pair.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults for the fetch front end and its decode consumer.
// Holds no logic, so it adds no latency and has no flow control.
package pipe_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head is read combinationally, so it has 1-cycle push-to-head latency.
// A push while full is dropped unless a pop happens in the same cycle, and a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot first, so a full FIFO can still accept a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: it owns the PC, issues requests to a 1-cycle imem and buffers returns, giving 2 cycles from request to if_valid.
// Requests are issued only when a prefetch slot is guaranteed free; a redirect flushes everything and restarts at the new PC.
module fetch_unit #(
  parameter int              PC_W       = pipe_pkg::PC_W,
  parameter int              INSTR_W    = pipe_pkg::INSTR_W,
  parameter int              IMEM_AW    = 21,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(pipe_pkg::RESET_PC),
  parameter int              PC_STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
  pkt_t            push_pkt, head_pkt;

  logic [CW-1:0]   occupancy, credit_limit;
  logic            issue;

  // A pop during a redirect is dropped: decode squashes that head anyway.
  assign fifo_pop  = !fifo_empty && if_ready && !redirect_valid;
  assign fifo_push = inflight_q && !redirect_valid;

  // Buffered plus in-flight entries must leave room for the reply to this cycle's request.
  assign occupancy    = CW'(fifo_count) + CW'(inflight_q);
  assign credit_limit = CW'(FIFO_DEPTH) + CW'(fifo_pop);
  assign issue        = !reset && !redirect_valid && (occupancy < credit_limit)
                        && (!fifo_full || fifo_pop);

  assign push_pkt = '{pc: req_pc_q, instr: imem_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (push_pkt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_pkt)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q[IMEM_AW-1:0];

  assign if_valid = !fifo_empty;
  assign if_pc    = fifo_empty ? '0 : head_pkt.pc;
  assign if_instr = fifo_empty ? '0 : head_pkt.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and scoreboarded checks of the fetch front end, with an imem model that returns the low address bits as data.
// Inputs are driven at the falling edge and outputs are sampled 1ns later.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [20:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [15:0] if_instr;
  logic [31:0] if_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= imem_req ? imem_addr[15:0] : 16'hDEAD;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    if_ready = 1'b1;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", if_pc); end
    n_cmp++; if (if_instr !== 16'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", if_instr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 21'd0) begin n_fail++; $display("FAIL rel_req0 got %b/%h want 1/0", imem_req, imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid0 got %b want 0", if_valid); end
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 21'd1) begin n_fail++; $display("FAIL rel_cyc1 got valid %b addr %h want 0/1", if_valid, imem_addr); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== 16'(i)) begin
        n_fail++; $display("FAIL stream_%0d got v%b pc %h instr %h want v1 pc %h", i, if_valid, if_pc, if_instr, i);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    if_ready = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (imem_req !== (k < 4)) begin n_fail++; $display("FAIL stall_req_%0d got %b want %b", k, imem_req, (k < 4)); end
      if (k >= 2) begin
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0) begin n_fail++; $display("FAIL stall_head_%0d got v%b pc %h want v1 pc 0", k, if_valid, if_pc); end
      end
    end
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(j)) begin n_fail++; $display("FAIL drain_%0d got v%b pc %h want v1 pc %h", j, if_valid, if_pc, j); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    if_ready = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    if_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_noissue got %b want 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got %b want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 21'h100) begin n_fail++; $display("FAIL redir_addr got %b/%h want 1/100", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap got %b want 0", if_valid); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 + 32'(j) || if_instr !== 16'h100 + 16'(j)) begin
        n_fail++; $display("FAIL redir_stream_%0d got v%b pc %h instr %h want pc %h", j, if_valid, if_pc, if_instr, 32'h100 + 32'(j));
      end
    end
  endtask

  task automatic test_back_to_back();
    if_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req0 got %b want 0", imem_req); end
    @(negedge clk);
    redirect_pc = 32'h80;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_req1 got req %b valid %b want 0/0", imem_req, if_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 21'h80) begin n_fail++; $display("FAIL b2b_addr got %b/%h want 1/80", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got %b want 0", if_valid); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'h80 + 32'(j)) begin n_fail++; $display("FAIL b2b_stream_%0d got v%b pc %h want %h", j, if_valid, if_pc, 32'h80 + 32'(j)); end
    end
  endtask

  task automatic test_wrap();
    if_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 21'h1F_FFFF) begin n_fail++; $display("FAIL wrap_addr got %h want 1fffff", imem_addr); end
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFF || if_instr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_top got v%b pc %h instr %h want ffffffff", if_valid, if_pc, if_instr); end
    @(negedge clk); #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 16'h0) begin n_fail++; $display("FAIL wrap_zero got v%b pc %h instr %h want 0", if_valid, if_pc, if_instr); end
    @(negedge clk); #1;
    n_cmp++; if (if_pc !== 32'h1) begin n_fail++; $display("FAIL wrap_one got %h want 1", if_pc); end
  endtask

  task automatic test_random_ready();
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic        hold_prev;
    int          issued;
    int          popped;
    int          delivered_after_reset;
    do_reset();
    reset = 1'b0;
    exp_pc = '0; held_pc = '0; hold_prev = 1'b0;
    issued = 0; popped = 0; delivered_after_reset = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      reset = (c == 200);
      if_ready = 1'($urandom_range(0, 1));
      #1;
      if (c == 200) begin
        exp_pc = '0; issued = 0; popped = 0; hold_prev = 1'b0;
      end else begin
        if (c == 201) begin
          n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_reset_empty got %b want 0", if_valid); end
        end
        n_cmp++;
        if (issued - popped > 4) begin n_fail++; $display("FAIL rnd_occupancy_%0d got %0d want <=4", c, issued - popped); end
        if (if_valid) begin
          if (hold_prev) begin
            n_cmp++; if (if_pc !== held_pc) begin n_fail++; $display("FAIL rnd_hold_%0d got %h want %h", c, if_pc, held_pc); end
          end
          if (if_ready) begin
            n_cmp++;
            if (if_pc !== exp_pc || if_instr !== exp_pc[15:0]) begin
              n_fail++; $display("FAIL rnd_order_%0d got pc %h instr %h want %h", c, if_pc, if_instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd1;
            popped++;
            if (c > 200) delivered_after_reset++;
          end
        end
        if (imem_req) issued++;
        hold_prev = if_valid && !if_ready;
        held_pc = if_pc;
      end
    end
    n_cmp++;
    if (delivered_after_reset < 40) begin n_fail++; $display("FAIL rnd_progress got %0d want >=40", delivered_after_reset); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_random_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
